pc_sequencer: RTL

- Program-counter and sequencing stage directly upstream of the instruction decoder/control unit.
- Holds the 10-bit PC that addresses instruction memory and computes the next PC from the decoder's jump/bzero/bnegative/mainAddress/HLT outputs.
- Latches the ALU zero/negative flags that conditional branches test.
- Stalls the core for the operator-confirmed "in" instruction and for halt; a resume pulse leaves halt.

---
 rtl/pc_sequencer_pkg.sv | 16 +
 rtl/pc_sequencer_button_sync_edge.sv | 29 ++
 rtl/pc_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer and the instruction decoder.
package pc_sequencer_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 10;

  // 2'b11 is unused; the sequencer treats it as illegal and recovers to RUN.
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT_IN = 2'b01,
    HALTED  = 2'b10
  } seq_state_t;

  localparam logic [5:0] OPC_IN  = 6'b011101;
  localparam logic [5:0] OPC_HLT = 6'b011100;

endpackage

// File: rtl/pc_sequencer_button_sync_edge.sv
// Two-flop synchronizer for an asynchronous operator button, followed by a
// rising-edge detector producing a one-cycle pulse.
module button_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= button;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  // Pulse decodes flops only, so consumers see it on the third edge after the press.
  assign pulse = sync_p1 & ~prev_p2;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and sequencing stage: next-PC selection, ALU flag latching,
// and stalling for the "in" instruction and for halt.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int RESET_PC   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  jump,
  input  logic                  bzero,
  input  logic                  bnegative,
  input  logic                  HLT,
  input  logic [ADDR_WIDTH-1:0] mainAddress,
  input  logic                  flag_enable,
  input  logic                  alu_zero,
  input  logic                  alu_negative,
  input  logic                  in_request,
  input  logic                  in_confirm,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  zero_flag,
  output logic                  negative_flag,
  output logic                  stall,
  output logic                  in_done,
  output logic                  halted
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_V = ADDR_WIDTH'(RESET_PC);

  seq_state_t            state;
  logic                  confirm_pulse;
  logic                  resume_pulse;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  branch_taken;

  button_sync_edge u_confirm_sync (
    .clock  (clock),
    .reset  (reset),
    .button (in_confirm),
    .pulse  (confirm_pulse)
  );

  button_sync_edge u_resume_sync (
    .clock  (clock),
    .reset  (reset),
    .button (resume),
    .pulse  (resume_pulse)
  );

  assign pc_inc = pc + 1'b1;

  // Branches test the registered flags, never this cycle's ALU result.
  assign branch_taken = jump
                      | (bzero & zero_flag)
                      | (bnegative & negative_flag);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      pc            <= RESET_PC_V;
      zero_flag     <= 1'b0;
      negative_flag <= 1'b0;
      in_done       <= 1'b0;
    end else begin
      in_done <= 1'b0;
      case (state)
        RUN: begin
          if (flag_enable) begin
            zero_flag     <= alu_zero;
            negative_flag <= alu_negative;
          end
          if (HLT) begin
            state <= HALTED;
          end else if (in_request) begin
            state <= WAIT_IN;
          end else if (branch_taken) begin
            pc <= mainAddress;
          end else begin
            pc <= pc_inc;
          end
        end
        WAIT_IN: begin
          if (confirm_pulse) begin
            in_done <= 1'b1;
            pc      <= pc_inc;
            state   <= RUN;
          end
        end
        HALTED: begin
          if (resume_pulse) begin
            pc    <= pc_inc;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign stall  = (state == WAIT_IN) || (state == HALTED);
  assign halted = (state == HALTED);

endmodule
